microcode_sequencer: RTL and testbench
======================================

# microcode_sequencer

Parametrised, table-driven successor to the fixed step-count control generator of the 65C02 core. Holds a writable microcode store of NUM_SEQ sequences × 2^STEP_W steps. On a start request it plays one sequence out, one registered control word per enabled clock. It supports per-step wait-for-ready, end-of-sequence marking, abort and error reporting. It sits between the instruction/interrupt decode logic (which chooses a sequence) and the datapath (which consumes the control word).

## Interface
Parameters:
- STEP_W, 4: step counter width; steps per sequence = 2^STEP_W.
- NUM_SEQ, 4: number of sequences; seq_id width SEQ_W = $clog2(NUM_SEQ), minimum 1.
- CTRL_W, 64: control word width. Default packing, MSB to LSB:
  - signal_set[4], data_bus_set[8], address_bus_set[6], load_store_execute[16]
  - alu_operations_regs[6], inc_dec_clr[10], status_flags[8], vector_operations[5], adb_to_pc[1]

Ports:
- fclk  in  1  clock; all logic is posedge.
- resb  in  1  reset. One clock; reset is asynchronous and active-low.
- clock_running  in  1  step enable; when low, sequencing freezes.
- ucode_we  in  1  microcode write strobe.
- ucode_addr  in  SEQ_W+STEP_W  write address {seq, step}.
- ucode_wdata  in  CTRL_W+2  {end, wait, ctrl}.
- start  in  1  sequence start request.
- seq_id  in  SEQ_W  sequence to run.
- start_rdy  out  1  start accepted this cycle if start=1; equals idle && !ucode_we && clock_running.
- rdy  in  1  datapath ready, consulted only for words with wait=1.
- abort  in  1  synchronous abort.
- err_clr  in  1  clears sticky errors.
- ctrl_word  out  CTRL_W  current control word (registered).
- step  out  STEP_W  index of the word on ctrl_word.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse.
- err  out  2  sticky {par_err, ovf_err}.

## Operation
- States: IDLE and RUN.
- Reset values: state IDLE; ctrl_word=0, step=0, busy=0, done=0, err=0. Store contents are undefined after reset.
- Writes: in IDLE, on ucode_we, store[ucode_addr] <= ucode_wdata. Writes are not gated by clock_running. Writes during RUN are dropped, with no flag.
- IDLE→RUN: on start && start_rdy. Latch seq_id, step<=0, ctrl_word<=store[{seq_id,0}].ctrl, busy<=1.
- RUN, while clock_running=1: the current word retires unless its wait=1 and rdy=0; in that case ctrl_word and step hold.
  - Retire with end=0 and step<2^STEP_W−1: step+1, load the next word.
  - Retire with end=1: ctrl_word<=0, step<=0, busy<=0, done<=1, go to IDLE.
  - Retire at step 2^STEP_W−1 with end=0: treated as end, and err[0] is set.
- While clock_running=0: everything holds (no retire, no start), except writes, abort and err_clr.
- abort (any state): ctrl_word<=0, step<=0, busy<=0, go to IDLE, no done pulse. Abort beats retire and start in the same cycle.
- err_clr zeroes err. If a new error occurs in the same cycle, the set wins.
- done is high for exactly one cycle and is otherwise 0.

## Timing
- Start latency: one cycle. Word 0 is visible in the cycle after the accepting edge.
- With no stalls, word k is visible k+1 cycles after acceptance. An N-word sequence raises done N+1 cycles after acceptance.
- Back-to-back: start_rdy is high in the done cycle, so a new sequence can be accepted then. There is no bubble beyond the done cycle.
- Stall: a word with wait=1 holds on ctrl_word for every cycle with rdy=0, and retires on the first edge with rdy=1 and clock_running=1.

## Configuration
- MSEQ_PARITY_EN defined:
  - Each stored word carries an extra even-parity bit over {end, wait, ctrl}, computed at write time.
  - An extra input, par_inject (1 bit), inverts the stored parity bit on a write.
  - A parity mismatch on a word being loaded into ctrl_word sets err[1] and behaves as abort.
- MSEQ_PARITY_EN undefined: no parity storage, no par_inject port, err[1] tied to 0.

## Test plan
- Reset mid-run: run a 5-word sequence, assert resb low at step 2 → ctrl_word=0, busy=0, err=0 immediately (asynchronous); start_rdy=1 after release.
- Basic play: seq 1 words ctrl=0x1…1 to 0x5…5, end on step 4; start seq_id=1 → ctrl_word shows 1..5 on cycles 1..5, done=1 on cycle 6, ctrl_word=0 after.
- Stall: step 2 has wait=1, rdy low for 3 cycles → word 3 is held 4 cycles, done is delayed 3 cycles. clock_running low for 2 cycles → identical hold.
- Overflow and abort: seq 2 has no end bits → 16 words, then done, err=2'b01; err_clr → err=0. Abort at step 3 → ctrl_word=0 next cycle, no done.
- Contention: start and ucode_we together in IDLE → write lands, start_rdy=0, no start. ucode_we during RUN → store unchanged (rerun and compare).
- MSEQ_PARITY_EN: write step 1 with par_inject=1, run → word 0 plays, then ctrl_word=0, err=2'b10, busy=0, no done.

Source files
------------

// File: rtl/microcode_sequencer.sv
// microcode_sequencer: plays one sequence from a writable microcode store, one control word per enabled clock.
// Optional feature macro MSEQ_PARITY_EN adds per-word even parity and a par_inject write input.
module microcode_sequencer #(
   parameter int STEP_W = 4,
   parameter int NUM_SEQ = 4,
   parameter int CTRL_W = 64,
   localparam int SEQ_W = (NUM_SEQ > 1) ? $clog2(NUM_SEQ) : 1
) (
   input  logic                    fclk,
   input  logic                    resb,
   input  logic                    clock_running,
   input  logic                    ucode_we,
   input  logic [SEQ_W+STEP_W-1:0] ucode_addr,
   input  logic [CTRL_W+1:0]       ucode_wdata,
`ifdef MSEQ_PARITY_EN
   input  logic                    par_inject,
`endif
   input  logic                    start,
   input  logic [SEQ_W-1:0]        seq_id,
   output logic                    start_rdy,
   input  logic                    rdy,
   input  logic                    abort,
   input  logic                    err_clr,
   output logic [CTRL_W-1:0]       ctrl_word,
   output logic [STEP_W-1:0]       step,
   output logic                    busy,
   output logic                    done,
   output logic [1:0]              err
);
   localparam int ADDR_W = SEQ_W + STEP_W;
`ifdef MSEQ_PARITY_EN
   localparam int WORD_W = CTRL_W + 3;
`else
   localparam int WORD_W = CTRL_W + 2;
`endif
   typedef enum logic {IDLE, RUN} state_t;
   state_t state, state_d;
   logic [WORD_W-1:0] store [2**ADDR_W];
   logic [WORD_W-1:0] wword, fetch;
   logic [ADDR_W-1:0] fetch_addr;
   logic [SEQ_W-1:0] seq_q, seq_d;
   logic [STEP_W-1:0] step_d, step_inc;
   logic [CTRL_W-1:0] ctrl_d;
   logic [1:0] err_d;
   logic end_q, end_d, wait_q, wait_d, done_d;
   logic idle, accept, retire, advance, finish, par_bad;

`ifdef MSEQ_PARITY_EN
   assign wword = {^ucode_wdata ^ par_inject, ucode_wdata};
`else
   assign wword = ucode_wdata;
`endif

   always_ff @(posedge fclk)
      if (ucode_we && idle) store[ucode_addr] <= wword;

   always_comb begin
      idle = state == IDLE;
      busy = !idle;
      start_rdy = idle && !ucode_we && clock_running;
      accept = start && start_rdy;
      retire = !idle && clock_running && !(wait_q && !rdy);
      advance = retire && !end_q && step != '1;
      finish = retire && !advance;
      step_inc = step + STEP_W'(1);
      fetch_addr = accept ? {seq_id, {STEP_W{1'b0}}} : {seq_q, step_inc};
      fetch = store[fetch_addr];
`ifdef MSEQ_PARITY_EN
      par_bad = (accept || advance) && ^fetch;
`else
      par_bad = 1'b0;
`endif
      state_d = state;
      seq_d = seq_q;
      step_d = step;
      ctrl_d = ctrl_word;
      end_d = end_q;
      wait_d = wait_q;
      done_d = 1'b0;
      err_d = err_clr ? 2'b00 : err;
      // abort outranks everything; a bad-parity load behaves like abort
      if (abort || par_bad || finish) begin
         state_d = IDLE;
         step_d = '0;
         ctrl_d = '0;
         end_d = 1'b0;
         wait_d = 1'b0;
         done_d = !abort && !par_bad;
         err_d[1] = err_d[1] | (par_bad && !abort);
         err_d[0] = err_d[0] | (finish && !abort && !end_q);
      end else if (accept || advance) begin
         state_d = RUN;
         seq_d = accept ? seq_id : seq_q;
         step_d = accept ? '0 : step_inc;
         {end_d, wait_d, ctrl_d} = fetch[CTRL_W+1:0];
      end
   end

   always_ff @(posedge fclk or negedge resb)
      if (!resb) begin
         state <= IDLE;
         seq_q <= '0;
         step <= '0;
         ctrl_word <= '0;
         end_q <= 1'b0;
         wait_q <= 1'b0;
         done <= 1'b0;
         err <= 2'b00;
      end else begin
         state <= state_d;
         seq_q <= seq_d;
         step <= step_d;
         ctrl_word <= ctrl_d;
         end_q <= end_d;
         wait_q <= wait_d;
         done <= done_d;
         err <= err_d;
      end
endmodule

// File: tb/tb_microcode_sequencer.sv
// tb_microcode_sequencer: directed checks of play, stall, overflow, abort, contention and reset.
module tb_microcode_sequencer;
   logic fclk = 0, resb = 0, clock_running = 1, ucode_we = 0, start = 0, rdy = 1, abort = 0, err_clr = 0;
   logic [5:0] ucode_addr = '0;
   logic [65:0] ucode_wdata = '0;
   logic [1:0] seq_id = '0;
   logic start_rdy, busy, done;
   logic [63:0] ctrl_word;
   logic [3:0] step;
   logic [1:0] err;
`ifdef MSEQ_PARITY_EN
   logic par_inject = 0;
`endif
   int vec = 0, bad = 0;
   localparam logic [63:0] K = 64'h1111_1111_1111_1111;

   always #5 fclk = ~fclk;

   microcode_sequencer dut (
      .fclk(fclk), .resb(resb), .clock_running(clock_running),
      .ucode_we(ucode_we), .ucode_addr(ucode_addr), .ucode_wdata(ucode_wdata),
`ifdef MSEQ_PARITY_EN
      .par_inject(par_inject),
`endif
      .start(start), .seq_id(seq_id), .start_rdy(start_rdy), .rdy(rdy),
      .abort(abort), .err_clr(err_clr), .ctrl_word(ctrl_word), .step(step),
      .busy(busy), .done(done), .err(err)
   );

   task automatic tick(input int n = 1);
      repeat (n) @(posedge fclk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vec++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_word(input string tag, input logic [63:0] c, input logic [3:0] st);
      chk({tag, "_ctrl"}, ctrl_word, c);
      chk({tag, "_step"}, 64'(step), 64'(st));
      chk({tag, "_busy"}, 64'(busy), 64'd1);
   endtask

   task automatic wr(input logic [1:0] s, input logic [3:0] st, input logic e, input logic w, input logic [63:0] c);
      ucode_we = 1;
      ucode_addr = {s, st};
      ucode_wdata = {e, w, c};
      tick();
      ucode_we = 0;
   endtask

   task automatic go(input logic [1:0] s);
      seq_id = s;
      start = 1;
      tick();
      start = 0;
   endtask

   initial begin
      tick(2);
      chk("rst_ctrl", ctrl_word, 64'd0);
      chk("rst_step", 64'(step), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      resb = 1;
      #1 chk("rst_start_rdy", 64'(start_rdy), 64'd1);
      // basic play of seq 1, five words
      for (int k = 0; k < 5; k++) wr(2'd1, 4'(k), k == 4, 1'b0, K * 64'(k + 1));
      go(2'd1);
      for (int k = 0; k < 5; k++) begin
         chk_word("basic", K * 64'(k + 1), 4'(k));
         chk("basic_nodone", 64'(done), 64'd0);
         tick();
      end
      chk("basic_done", 64'(done), 64'd1);
      chk("basic_ctrl0", ctrl_word, 64'd0);
      chk("basic_idle", 64'(busy), 64'd0);
      chk("b2b_start_rdy", 64'(start_rdy), 64'd1);
      go(2'd1);
      chk_word("b2b", K, 4'd0);
      chk("b2b_done_low", 64'(done), 64'd0);
      tick(3);
      chk_word("pre_abort", K * 64'd4, 4'd3);
      abort = 1;
      tick();
      abort = 0;
      chk("abort_ctrl", ctrl_word, 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_step", 64'(step), 64'd0);
      chk("abort_nodone", 64'(done), 64'd0);
      tick();
      chk("abort_nodone2", 64'(done), 64'd0);
      // stall on rdy at step 2 of seq 3
      for (int k = 0; k < 5; k++) wr(2'd3, 4'(k), k == 4, k == 2, 64'hA0 + 64'(k));
      go(2'd3);
      rdy = 0;
      tick(2);
      chk_word("stall_w2", 64'hA2, 4'd2);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk_word("stall_hold", 64'hA2, 4'd2);
      end
      rdy = 1;
      tick();
      chk_word("stall_w3", 64'hA3, 4'd3);
      tick(2);
      chk("stall_done", 64'(done), 64'd1);
      // clock_running low for two cycles
      go(2'd3);
      tick();
      chk_word("cr_w1", 64'hA1, 4'd1);
      clock_running = 0;
      #1 chk("cr_start_rdy", 64'(start_rdy), 64'd0);
      tick();
      chk_word("cr_hold1", 64'hA1, 4'd1);
      tick();
      chk_word("cr_hold2", 64'hA1, 4'd1);
      clock_running = 1;
      tick();
      chk_word("cr_w2", 64'hA2, 4'd2);
      tick(3);
      chk("cr_done", 64'(done), 64'd1);
      // overflow: seq 2 has no end bits
      for (int k = 0; k < 16; k++) wr(2'd2, 4'(k), 1'b0, 1'b0, 64'(k));
      go(2'd2);
      for (int k = 0; k < 16; k++) begin
         chk("ovf_ctrl", ctrl_word, 64'(k));
         tick();
      end
      chk("ovf_done", 64'(done), 64'd1);
      chk("ovf_err", 64'(err), 64'd1);
      tick();
      chk("ovf_sticky", 64'(err), 64'd1);
      chk("ovf_done_pulse", 64'(done), 64'd0);
      err_clr = 1;
      tick();
      err_clr = 0;
      chk("err_clr", 64'(err), 64'd0);
      go(2'd2);
      tick(16);
      chk("ovf2_err", 64'(err), 64'd1);
      // contention: start with write in idle
      seq_id = 2'd1;
      start = 1;
      ucode_we = 1;
      ucode_addr = {2'd1, 4'd0};
      ucode_wdata = {2'b00, 64'h7777_7777_7777_7777};
      #1 chk("cont_start_rdy", 64'(start_rdy), 64'd0);
      tick();
      start = 0;
      ucode_we = 0;
      chk("cont_nostart", 64'(busy), 64'd0);
      go(2'd1);
      chk_word("cont_w0", 64'h7777_7777_7777_7777, 4'd0);
      tick();
      ucode_we = 1;
      ucode_addr = {2'd1, 4'd3};
      ucode_wdata = {2'b00, 64'hDEAD_BEEF_DEAD_BEEF};
      tick();
      ucode_we = 0;
      tick();
      chk_word("run_write_dropped", K * 64'd4, 4'd3);
      tick(2);
      chk("cont_done", 64'(done), 64'd1);
      // asynchronous reset mid-run with sticky error still set
      go(2'd1);
      tick(2);
      chk_word("pre_reset", K * 64'd3, 4'd2);
      resb = 0;
      #1;
      chk("arst_ctrl", ctrl_word, 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_err", 64'(err), 64'd0);
      tick();
      resb = 1;
      #1 chk("arst_start_rdy", 64'(start_rdy), 64'd1);
`ifdef MSEQ_PARITY_EN
      wr(2'd0, 4'd0, 1'b0, 1'b0, 64'h5);
      par_inject = 1;
      wr(2'd0, 4'd1, 1'b1, 1'b0, 64'h6);
      par_inject = 0;
      go(2'd0);
      chk_word("par_w0", 64'h5, 4'd0);
      tick();
      chk("par_ctrl", ctrl_word, 64'd0);
      chk("par_err", 64'(err), 64'd2);
      chk("par_busy", 64'(busy), 64'd0);
      chk("par_nodone", 64'(done), 64'd0);
      tick();
      chk("par_nodone2", 64'(done), 64'd0);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end
endmodule
